decoder_scan_nx: RTL and testbench

- Parametrised, registered N-to-2^N one-hot decoder with enable; successor to the fixed 2-to-4 enable decoder.
- Adds an auto-scan mode. An internal index counter steps through every output with a programmable dwell time.
- Drives time-multiplexed selects (display digit enables, bank/row strobes) directly or as a free-running scanner.

---
 rtl/decoder_scan_nx.sv | 115 +++++++++++
 tb/tb_decoder_scan_nx.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_nx.sv
// ---------------------------------------------------------------------------
// decoder_scan_nx
//   Registered N-to-2^N one-hot select decoder with enable and an auto-scan
//   mode. In scan mode an internal index steps through every output and
//   holds each one for dwell+1 cycles.
//
//   Optional feature: define DECODER_SCAN_ACTIVE_LOW_EN for a one-cold,
//   active-low y (common-anode drive). In that build the reset and OFF value
//   of y is all ones. idx and wrap are the same in both builds.
//
// Parameters
//   SEL_W   : width of w / idx; y is 2**SEL_W wide
//   DWELL_W : width of dwell and the internal dwell counter
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset
//   en    in   0 -> y inactive, scan paused (idx/cnt hold)
//   mode  in   0 = direct decode of w, 1 = auto-scan
//   w     in   [SEL_W]   direct-mode select index
//   dwell in   [DWELL_W] scan hold time minus one
//   y     out  [2**SEL_W] registered one-hot (or one-cold) select
//   idx   out  [SEL_W]   registered index of the selected output
//   wrap  out  one-cycle pulse when the scan index goes max -> 0
// ---------------------------------------------------------------------------

// One output lane: registers its y bit from the shared next-select index.
module decoder_scan_nx_lane #(
    parameter int   SEL_W = 2,
    parameter int   LANE  = 0,
    parameter logic ACT   = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             on,
    input  logic [SEL_W-1:0] sel,
    output logic             y_bit
);
    localparam logic [SEL_W-1:0] LANE_ID = SEL_W'(LANE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            y_bit <= ~ACT;
        else
            y_bit <= (on && (sel == LANE_ID)) ? ACT : ~ACT;
    end
endmodule

module decoder_scan_nx #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      w,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [2**SEL_W-1:0]   y,
    output logic [SEL_W-1:0]      idx,
    output logic                  wrap
);
    localparam int NUM_LANES = 2**SEL_W;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam logic Y_ACT = 1'b0;
`else
    localparam logic Y_ACT = 1'b1;
`endif

    logic [DWELL_W-1:0] cnt;
    logic               adv;       // dwell expired: step to next index
    logic [SEL_W-1:0]   scan_idx;  // idx after this scan cycle
    logic [SEL_W-1:0]   sel_next;  // index the lanes will light next

    // >= rather than == so a dwell shrunk below cnt forces an advance
    // instead of letting cnt run on to wrap around.
    always_comb begin
        adv      = (cnt >= dwell);
        scan_idx = adv ? (idx + SEL_W'(1)) : idx;
        sel_next = mode ? scan_idx : w;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx  <= '0;
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (!en) begin
            wrap <= 1'b0;
        end else if (!mode) begin
            idx  <= w;
            cnt  <= '0;
            wrap <= 1'b0;
        end else begin
            idx  <= scan_idx;
            cnt  <= adv ? '0 : (cnt + DWELL_W'(1));
            wrap <= adv && (idx == {SEL_W{1'b1}});
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        decoder_scan_nx_lane #(
            .SEL_W (SEL_W),
            .LANE  (l),
            .ACT   (Y_ACT)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .on    (en),
            .sel   (sel_next),
            .y_bit (y[l])
        );
    end
endmodule

// File: tb/tb_decoder_scan_nx.sv
// Bench for decoder_scan_nx (SEL_W=2, DWELL_W=4): directed steps followed by
// a randomized run, each checked against a cycle model built from the
// behavioural rules (integer index/counter bookkeeping).
module tb_decoder_scan_nx;
    localparam int SEL_W   = 2;
    localparam int DWELL_W = 4;
    localparam int NL      = 2**SEL_W;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic               clk, rst, en, mode;
    logic [SEL_W-1:0]   w;
    logic [DWELL_W-1:0] dwell;
    logic [NL-1:0]      y;
    logic [SEL_W-1:0]   idx;
    logic               wrap;

    int total = 0;
    int bad   = 0;

    // reference state
    int            m_idx, m_cnt;
    bit            m_wrap;
    logic [NL-1:0] m_y;

    decoder_scan_nx #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .w(w),
        .dwell(dwell), .y(y), .idx(idx), .wrap(wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NL-1:0] sel_pat(input bit on, input int i);
        logic [NL-1:0] v;
        v = '0;
        if (on) v[i] = 1'b1;
        return ACT_LOW ? ~v : v;
    endfunction

    function automatic logic [NL-1:0] pol(input logic [NL-1:0] v);
        return ACT_LOW ? ~v : v;
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_cnt  = 0;
        m_wrap = 1'b0;
        m_y    = sel_pat(1'b0, 0);
    endtask

    // One clock edge of the reference, using the inputs held across the edge.
    task automatic model_edge();
        if (!en) begin
            m_y    = sel_pat(1'b0, 0);
            m_wrap = 1'b0;
        end else if (!mode) begin
            m_idx  = int'(w);
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_y    = sel_pat(1'b1, m_idx);
        end else begin
            if (m_cnt >= int'(dwell)) begin
                m_cnt  = 0;
                m_wrap = (m_idx == NL - 1);
                m_idx  = (m_idx + 1) % NL;
            end else begin
                m_cnt  = m_cnt + 1;
                m_wrap = 1'b0;
            end
            m_y = sel_pat(1'b1, m_idx);
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (y === m_y) else begin
            bad++; $error("FAIL %s y got=%b exp=%b", tag, y, m_y);
        end
        total++;
        assert (idx === SEL_W'(m_idx)) else begin
            bad++; $error("FAIL %s idx got=%0d exp=%0d", tag, idx, m_idx);
        end
        total++;
        assert (wrap === m_wrap) else begin
            bad++; $error("FAIL %s wrap got=%b exp=%b", tag, wrap, m_wrap);
        end
    endtask

    // Hard-coded expectation for y, independent of the model.
    task automatic check_y(input string tag, input logic [NL-1:0] exp);
        total++;
        assert (y === exp) else begin
            bad++; $error("FAIL %s y got=%b exp=%b", tag, y, exp);
        end
    endtask

    task automatic check_wrap(input string tag, input bit exp);
        total++;
        assert (wrap === exp) else begin
            bad++; $error("FAIL %s wrap got=%b exp=%b", tag, wrap, exp);
        end
    endtask

    // Inputs change only #1 after a rising edge; outputs checked there too.
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    // Asynchronous reset pulse between edges.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check(tag);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; w = '0; dwell = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por");
        rst = 1'b0;

        // load something nonzero, then async reset with en=1, mode=1
        en = 1'b1; mode = 1'b0; w = 2'd3;
        tick("pre_rst");
        check_y("pre_rst_y", pol(4'b1000));
        en = 1'b1; mode = 1'b1; #2;
        pulse_reset("async_rst");
        check_y("async_rst_y", pol(4'b0000));
        en = 1'b0;
        tick("rel_off");
        check_y("rel_off_y", pol(4'b0000));

        // direct decode
        en = 1'b1; mode = 1'b0;
        for (int i = 0; i < NL; i++) begin
            w = SEL_W'(i);
            tick("direct");
            check_y("direct_y", pol(4'b0001 << i));
        end
        en = 1'b0; w = 2'd2;
        tick("direct_off");
        check_y("direct_off_y", pol(4'b0000));

        // scan, dwell=0 from reset: one step per cycle, wrap on 3->0
        pulse_reset("rst_scan0");
        en = 1'b1; mode = 1'b1; dwell = '0;
        for (int i = 0; i < 6; i++) tick("scan0");
        check_y("scan0_last", pol(4'b0100));
        // back around: idx 3 -> 0 must pulse wrap
        tick("scan0_b");
        tick("scan0_wrap");
        check_y("scan0_wrap_y", pol(4'b0001));
        check_wrap("scan0_wrap_pulse", 1'b1);
        tick("scan0_after");
        check_wrap("scan0_wrap_drop", 1'b0);

        // scan, dwell=2, pause mid-hold and resume
        pulse_reset("rst_scan2");
        dwell = 4'd2;
        for (int i = 0; i < 5; i++) tick("scan2");
        en = 1'b0;
        for (int i = 0; i < 4; i++) tick("scan2_pause");
        en = 1'b1;
        for (int i = 0; i < 8; i++) tick("scan2_resume");

        // dwell shrink below cnt, mode switches
        pulse_reset("rst_shrink");
        mode = 1'b0; w = 2'd1; tick("shrink_direct");
        mode = 1'b1; dwell = 4'd9;
        for (int i = 0; i < 6; i++) tick("shrink_count");
        dwell = 4'd3;
        tick("shrink_adv");
        check_y("shrink_adv_y", pol(4'b0100));
        mode = 1'b0; w = 2'd3;
        tick("to_direct");
        check_y("to_direct_y", pol(4'b1000));
        mode = 1'b1;
        for (int i = 0; i < 3; i++) tick("from_direct_hold");
        check_y("from_direct_hold_y", pol(4'b1000));
        tick("from_direct_wrap");
        check_y("from_direct_wrap_y", pol(4'b0001));
        check_wrap("from_direct_wrap_pulse", 1'b1);

        // dwell at max: 16 cycles per output
        pulse_reset("rst_max");
        dwell = '1;
        for (int i = 0; i < 40; i++) tick("dwell_max");

        // randomized run
        for (int i = 0; i < 600; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            mode  = ($urandom_range(0, 4) != 0);
            w     = SEL_W'($urandom);
            if ($urandom_range(0, 7) == 0)
                dwell = ($urandom_range(0, 3) == 0) ? DWELL_W'($urandom)
                                                    : DWELL_W'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0)
                pulse_reset("rand_rst");
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Keep the run bounded even if something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
